alu_rs: RTL and testbench
=========================

Name: alu_rs

Overview:
Reservation station that sits in front of the ALU: it is the producer side of the ALU op/operand interface.
- Accepts decoded integer ops from the dispatch stage.
- Tracks unresolved source operands by ROB tag and captures their values from two CDB broadcast ports.
- Issues at most one ready op per cycle to the ALU as a registered op/A/B/tag bundle.
- Flushes all state on the pipeline clear signal.

Parameters:
RS_SIZE, 8, number of entries; power of two, 2..16.
TAG_W, 4, ROB tag width.
XLEN, 32, operand width.

Ports:
clk_in  input  1  clock.
rst_in  input  1  reset; asynchronous, active-low.
rdy_in  input  1  global enable; when low, all state and outputs hold.
clear  input  1  synchronous flush (branch mispredict).
disp_valid  input  1  dispatch request this cycle.
disp_op  input  4  ALU opcode (ADD..BEQ encoding from the shared package).
disp_vj  input  XLEN  operand j value, meaningful when disp_qj_busy=0.
disp_qj_busy  input  1  operand j is pending.
disp_qj  input  TAG_W  producer tag for operand j.
disp_vk, disp_qk_busy, disp_qk  input  XLEN/1/TAG_W  same fields for operand k.
disp_dest  input  TAG_W  ROB tag of this op.
rs_full  output  1  no free entry; dispatch must not assert disp_valid.
cdb0_valid, cdb0_tag, cdb0_value  input  1/TAG_W/XLEN  broadcast port 0 (ALU result).
cdb1_valid, cdb1_tag, cdb1_value  input  1/TAG_W/XLEN  broadcast port 1 (load unit).
issue_valid  output  1  registered; the op bundle below is valid this cycle.
issue_op  output  4  registered opcode to the ALU.
issue_a  output  XLEN  registered operand A (from vj).
issue_b  output  XLEN  registered operand B (from vk).
issue_dest  output  TAG_W  registered ROB tag of the issued op.

Behaviour:
- Reset (rst_in=0, asynchronous): all entries not-busy; issue_valid=0; issue_op/a/b/dest=0; rs_full=0.
- Priority order: reset > rdy_in low (full hold, no state change, outputs held) > clear > normal operation.
- clear: all entries become not-busy and issue_valid=0 at the next edge. Dispatch and CDB in the same cycle are ignored.
- rs_full: combinational; high iff all RS_SIZE entries are busy at the start of the cycle. An entry freed by issue in the same cycle does not lower rs_full until the next cycle.
- Dispatch:
  - When disp_valid=1 and rs_full=0, write the lowest-index free entry at the edge.
  - When disp_valid=1 and rs_full=1, the request is dropped. This is a protocol violation; the bench flags it.
- Same-cycle CDB snoop at dispatch: if disp_qj_busy=1 and a valid CDB tag equals disp_qj, the entry stores the CDB value with qj_busy=0. Same for k.
- Wakeup of stored entries: each busy entry with qj_busy=1 compares qj against both CDBs each cycle. On a match it captures the value and clears qj_busy. Same for k. If both CDBs match the same tag, cdb0 wins.
- Ready: an entry is ready when it is busy, qj_busy=0 and qk_busy=0, evaluated on registered state at the start of the cycle.
- Issue:
  - Each cycle, the lowest-index ready entry is selected. At the edge, issue_* are loaded from it, issue_valid=1 and the entry is freed.
  - If no entry is ready, issue_valid=0 and the issue_* data outputs hold their previous values.
  - The ALU is always able to accept, so there is no backpressure.
- Latency:
  - Op dispatched with both operands ready (or snooped) at edge E0: issue_valid high after E1.
  - Op woken by a CDB at edge E0: issue_valid high after E1.
- Throughput: one dispatch and one issue per cycle, concurrently.
- Same-edge dispatch and free of the same slot is impossible: a slot is only written when it is free at the start of the cycle.
- Operand width: values are stored and passed verbatim. Shift amounts and signedness are the ALU's concern.

Decomposition:
- Shared package holds:
  - the 4-bit ALU opcode constants ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLL=0101, SRL=0110, SRA=0111, SLT=1000, SLTU=1001, BEQ=1010;
  - TAG_W and XLEN defaults;
  - the RS entry field layout.
- One natural sub-module: rs_pick_lowest, a parameterised priority encoder returning the index and found-flag of the lowest set bit. It is instantiated twice: once for the free-slot search, once for the ready-entry search.

Test Plan:
1. Reset then dispatch ADD, vj=5, vk=7, both ready, dest=3 -> next cycle issue_valid=1, issue_op=0000, issue_a=5, issue_b=7, issue_dest=3; following cycle issue_valid=0.
2. Dispatch SUB with qj_busy=1, qj=9; three idle cycles -> no issue. Then cdb1_valid=1, tag=9, value=0x100 -> issue_valid one cycle later with issue_a=0x100.
3. Dispatch with qk_busy=1, qk=2 in the same cycle as cdb0_valid=1, tag=2, value=42 -> entry captures 42; issue_valid next cycle, issue_b=42.
4. Fill 8 entries, all waiting on tag 1 -> rs_full=1. Broadcast tag 1 -> 8 consecutive issues in index order; rs_full drops the cycle after the first issue.
5. Entries pending, then clear=1 alongside disp_valid=1 -> no issue afterwards; rs_full=0; a later CDB of the old tags issues nothing.
6. rdy_in=0 for 4 cycles while an entry is ready and a CDB fires -> outputs and state unchanged. rdy_in=1 -> issue resumes; the CDB fired during the hold is not captured.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station: opcode encoding,
// default widths and the default-width layout of one station entry.
package alu_rs_pkg;

    localparam int OP_W      = 4;
    localparam int TAG_W_DEF = 4;
    localparam int XLEN_DEF  = 32;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001,
        ALU_BEQ  = 4'b1010
    } alu_op_e;

    // One station entry at the default widths. The top module keeps the same
    // fields as parallel arrays so TAG_W and XLEN stay overridable.
    typedef struct packed {
        logic                 busy;
        logic [OP_W-1:0]      op;
        logic [XLEN_DEF-1:0]  vj;
        logic                 qj_busy;
        logic [TAG_W_DEF-1:0] qj;
        logic [XLEN_DEF-1:0]  vk;
        logic                 qk_busy;
        logic [TAG_W_DEF-1:0] qk;
        logic [TAG_W_DEF-1:0] dest;
    } rs_entry_t;

endpackage

// File: rtl/alu_rs_pick_lowest.sv
// Priority encoder: index of the lowest set request bit plus a found flag.
module rs_pick_lowest #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// Reservation station in front of the ALU: takes dispatched ops, waits for
// their source operands on the two CDB ports and issues one ready op per cycle.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_SIZE = 8,
    parameter int TAG_W   = TAG_W_DEF,
    parameter int XLEN    = XLEN_DEF
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             clear,

    input  logic             disp_valid,
    input  logic [OP_W-1:0]  disp_op,
    input  logic [XLEN-1:0]  disp_vj,
    input  logic             disp_qj_busy,
    input  logic [TAG_W-1:0] disp_qj,
    input  logic [XLEN-1:0]  disp_vk,
    input  logic             disp_qk_busy,
    input  logic [TAG_W-1:0] disp_qk,
    input  logic [TAG_W-1:0] disp_dest,
    output logic             rs_full,

    input  logic             cdb0_valid,
    input  logic [TAG_W-1:0] cdb0_tag,
    input  logic [XLEN-1:0]  cdb0_value,
    input  logic             cdb1_valid,
    input  logic [TAG_W-1:0] cdb1_tag,
    input  logic [XLEN-1:0]  cdb1_value,

    output logic             issue_valid,
    output logic [OP_W-1:0]  issue_op,
    output logic [XLEN-1:0]  issue_a,
    output logic [XLEN-1:0]  issue_b,
    output logic [TAG_W-1:0] issue_dest
);

    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    logic [RS_SIZE-1:0] busy_q,    busy_d;
    logic [RS_SIZE-1:0] qj_busy_q, qj_busy_d;
    logic [RS_SIZE-1:0] qk_busy_q, qk_busy_d;
    logic [OP_W-1:0]    op_q   [RS_SIZE];
    logic [OP_W-1:0]    op_d   [RS_SIZE];
    logic [XLEN-1:0]    vj_q   [RS_SIZE];
    logic [XLEN-1:0]    vj_d   [RS_SIZE];
    logic [XLEN-1:0]    vk_q   [RS_SIZE];
    logic [XLEN-1:0]    vk_d   [RS_SIZE];
    logic [TAG_W-1:0]   qj_q   [RS_SIZE];
    logic [TAG_W-1:0]   qj_d   [RS_SIZE];
    logic [TAG_W-1:0]   qk_q   [RS_SIZE];
    logic [TAG_W-1:0]   qk_d   [RS_SIZE];
    logic [TAG_W-1:0]   dest_q [RS_SIZE];
    logic [TAG_W-1:0]   dest_d [RS_SIZE];

    logic               issue_valid_q, issue_valid_d;
    logic [OP_W-1:0]    issue_op_q,    issue_op_d;
    logic [XLEN-1:0]    issue_a_q,     issue_a_d;
    logic [XLEN-1:0]    issue_b_q,     issue_b_d;
    logic [TAG_W-1:0]   issue_dest_q,  issue_dest_d;

    logic [RS_SIZE-1:0] free_vec;
    logic [RS_SIZE-1:0] ready_vec;
    logic [IDX_W-1:0]   free_idx;
    logic               free_found;
    logic [IDX_W-1:0]   rdy_idx;
    logic               rdy_found;

    logic               disp_j_busy;
    logic [XLEN-1:0]    disp_j_val;
    logic               disp_k_busy;
    logic [XLEN-1:0]    disp_k_val;

    // Free/ready masks and the full flag, all from registered entry state.
    always_comb begin
        free_vec  = ~busy_q;
        ready_vec = busy_q & ~qj_busy_q & ~qk_busy_q;
        rs_full   = &busy_q;
    end

    rs_pick_lowest #(.N(RS_SIZE), .IDX_W(IDX_W)) u_pick_free (
        .req   (free_vec),
        .idx   (free_idx),
        .found (free_found)
    );

    rs_pick_lowest #(.N(RS_SIZE), .IDX_W(IDX_W)) u_pick_ready (
        .req   (ready_vec),
        .idx   (rdy_idx),
        .found (rdy_found)
    );

    // Operand resolution for the incoming op, snooping both CDBs (cdb0 first)
    // so a value broadcast in the dispatch cycle is not lost.
    always_comb begin
        disp_j_busy = disp_qj_busy;
        disp_j_val  = disp_vj;
        if (disp_qj_busy) begin
            if (cdb0_valid && cdb0_tag == disp_qj) begin
                disp_j_busy = 1'b0;
                disp_j_val  = cdb0_value;
            end else if (cdb1_valid && cdb1_tag == disp_qj) begin
                disp_j_busy = 1'b0;
                disp_j_val  = cdb1_value;
            end
        end
        disp_k_busy = disp_qk_busy;
        disp_k_val  = disp_vk;
        if (disp_qk_busy) begin
            if (cdb0_valid && cdb0_tag == disp_qk) begin
                disp_k_busy = 1'b0;
                disp_k_val  = cdb0_value;
            end else if (cdb1_valid && cdb1_tag == disp_qk) begin
                disp_k_busy = 1'b0;
                disp_k_val  = cdb1_value;
            end
        end
    end

    // Next state: clear wipes occupancy; otherwise issue, wake up waiting
    // operands and accept a dispatch into the lowest free slot.
    always_comb begin
        busy_d        = busy_q;
        qj_busy_d     = qj_busy_q;
        qk_busy_d     = qk_busy_q;
        op_d          = op_q;
        vj_d          = vj_q;
        vk_d          = vk_q;
        qj_d          = qj_q;
        qk_d          = qk_q;
        dest_d        = dest_q;
        issue_valid_d = 1'b0;
        issue_op_d    = issue_op_q;
        issue_a_d     = issue_a_q;
        issue_b_d     = issue_b_q;
        issue_dest_d  = issue_dest_q;

        if (clear) begin
            busy_d = '0;
        end else begin
            if (rdy_found) begin
                issue_valid_d   = 1'b1;
                issue_op_d      = op_q[rdy_idx];
                issue_a_d       = vj_q[rdy_idx];
                issue_b_d       = vk_q[rdy_idx];
                issue_dest_d    = dest_q[rdy_idx];
                busy_d[rdy_idx] = 1'b0;
            end

            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy_q[i] && qj_busy_q[i]) begin
                    if (cdb0_valid && cdb0_tag == qj_q[i]) begin
                        vj_d[i]      = cdb0_value;
                        qj_busy_d[i] = 1'b0;
                    end else if (cdb1_valid && cdb1_tag == qj_q[i]) begin
                        vj_d[i]      = cdb1_value;
                        qj_busy_d[i] = 1'b0;
                    end
                end
                if (busy_q[i] && qk_busy_q[i]) begin
                    if (cdb0_valid && cdb0_tag == qk_q[i]) begin
                        vk_d[i]      = cdb0_value;
                        qk_busy_d[i] = 1'b0;
                    end else if (cdb1_valid && cdb1_tag == qk_q[i]) begin
                        vk_d[i]      = cdb1_value;
                        qk_busy_d[i] = 1'b0;
                    end
                end
            end

            if (disp_valid && !rs_full && free_found) begin
                busy_d[free_idx]    = 1'b1;
                op_d[free_idx]      = disp_op;
                vj_d[free_idx]      = disp_j_val;
                qj_busy_d[free_idx] = disp_j_busy;
                qj_d[free_idx]      = disp_qj;
                vk_d[free_idx]      = disp_k_val;
                qk_busy_d[free_idx] = disp_k_busy;
                qk_d[free_idx]      = disp_qk;
                dest_d[free_idx]    = disp_dest;
            end
        end
    end

    // State registers; rdy_in low freezes everything.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q        <= '0;
            qj_busy_q     <= '0;
            qk_busy_q     <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                op_q[i]   <= '0;
                vj_q[i]   <= '0;
                vk_q[i]   <= '0;
                qj_q[i]   <= '0;
                qk_q[i]   <= '0;
                dest_q[i] <= '0;
            end
            issue_valid_q <= 1'b0;
            issue_op_q    <= '0;
            issue_a_q     <= '0;
            issue_b_q     <= '0;
            issue_dest_q  <= '0;
        end else if (rdy_in) begin
            busy_q        <= busy_d;
            qj_busy_q     <= qj_busy_d;
            qk_busy_q     <= qk_busy_d;
            for (int i = 0; i < RS_SIZE; i++) begin
                op_q[i]   <= op_d[i];
                vj_q[i]   <= vj_d[i];
                vk_q[i]   <= vk_d[i];
                qj_q[i]   <= qj_d[i];
                qk_q[i]   <= qk_d[i];
                dest_q[i] <= dest_d[i];
            end
            issue_valid_q <= issue_valid_d;
            issue_op_q    <= issue_op_d;
            issue_a_q     <= issue_a_d;
            issue_b_q     <= issue_b_d;
            issue_dest_q  <= issue_dest_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_op    = issue_op_q;
    assign issue_a     = issue_a_q;
    assign issue_b     = issue_b_q;
    assign issue_dest  = issue_dest_q;

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: expected issue bundles are queued when the
// stimulus is driven and compared as the station issues them.
module tb_alu_rs;
    import alu_rs_pkg::*;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  dest;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear;
    logic        disp_valid;
    logic [3:0]  disp_op;
    logic [31:0] disp_vj;
    logic        disp_qj_busy;
    logic [3:0]  disp_qj;
    logic [31:0] disp_vk;
    logic        disp_qk_busy;
    logic [3:0]  disp_qk;
    logic [3:0]  disp_dest;
    logic        rs_full;
    logic        cdb0_valid;
    logic [3:0]  cdb0_tag;
    logic [31:0] cdb0_value;
    logic        cdb1_valid;
    logic [3:0]  cdb1_tag;
    logic [31:0] cdb1_value;
    logic        issue_valid;
    logic [3:0]  issue_op;
    logic [31:0] issue_a;
    logic [31:0] issue_b;
    logic [3:0]  issue_dest;

    exp_t sb_q[$];
    exp_t last_exp;
    int   check_cnt = 0;
    int   fail_cnt  = 0;

    alu_rs #(.RS_SIZE(8), .TAG_W(4), .XLEN(32)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .clear        (clear),
        .disp_valid   (disp_valid),
        .disp_op      (disp_op),
        .disp_vj      (disp_vj),
        .disp_qj_busy (disp_qj_busy),
        .disp_qj      (disp_qj),
        .disp_vk      (disp_vk),
        .disp_qk_busy (disp_qk_busy),
        .disp_qk      (disp_qk),
        .disp_dest    (disp_dest),
        .rs_full      (rs_full),
        .cdb0_valid   (cdb0_valid),
        .cdb0_tag     (cdb0_tag),
        .cdb0_value   (cdb0_value),
        .cdb1_valid   (cdb1_valid),
        .cdb1_tag     (cdb1_tag),
        .cdb1_value   (cdb1_value),
        .issue_valid  (issue_valid),
        .issue_op     (issue_op),
        .issue_a      (issue_a),
        .issue_b      (issue_b),
        .issue_dest   (issue_dest)
    );

    // 10 ns clock.
    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_cnt++;
        if (actual !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] op,
                                 input logic [31:0] vj, input logic qjb, input logic [3:0] qj,
                                 input logic [31:0] vk, input logic qkb, input logic [3:0] qk,
                                 input logic [3:0] dest);
        disp_valid   = v;
        disp_op      = op;
        disp_vj      = vj;
        disp_qj_busy = qjb;
        disp_qj      = qj;
        disp_vk      = vk;
        disp_qk_busy = qkb;
        disp_qk      = qk;
        disp_dest    = dest;
    endtask

    task automatic setCdb(input int port, input logic v, input logic [3:0] tag,
                          input logic [31:0] value);
        if (port == 0) begin
            cdb0_valid = v;
            cdb0_tag   = tag;
            cdb0_value = value;
        end else begin
            cdb1_valid = v;
            cdb1_tag   = tag;
            cdb1_value = value;
        end
    endtask

    task automatic pushExp(input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] dest);
        exp_t e;
        e.op   = op;
        e.a    = a;
        e.b    = b;
        e.dest = dest;
        sb_q.push_back(e);
    endtask

    // One clock: sample #1 after the edge and retire any issued bundle
    // against the scoreboard (only for edges where the station was enabled).
    task automatic stepCycle();
        logic active;
        exp_t e;
        if (disp_valid)
            checkOutput("disp_when_full", {63'd0, rs_full}, 64'd0);
        active = rdy_in;
        @(posedge clk_in);
        #1;
        if (active && issue_valid) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_issue", {63'd0, issue_valid}, 64'd0);
            end else begin
                e = sb_q.pop_front();
                last_exp = e;
                checkOutput("issue_op",   {60'd0, issue_op},   {60'd0, e.op});
                checkOutput("issue_a",    {32'd0, issue_a},    {32'd0, e.a});
                checkOutput("issue_b",    {32'd0, issue_b},    {32'd0, e.b});
                checkOutput("issue_dest", {60'd0, issue_dest}, {60'd0, e.dest});
            end
        end
    endtask

    task automatic expectValid(input string tag, input logic v);
        checkOutput(tag, {63'd0, issue_valid}, {63'd0, v});
    endtask

    task automatic expectFull(input string tag, input logic f);
        checkOutput(tag, {63'd0, rs_full}, {63'd0, f});
    endtask

    initial begin
        rst_in = 1'b0;
        rdy_in = 1'b1;
        clear  = 1'b0;
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
        setCdb(0, 1'b0, 4'd0, 32'd0);
        setCdb(1, 1'b0, 4'd0, 32'd0);
        last_exp = '{op: 4'd0, a: 32'd0, b: 32'd0, dest: 4'd0};

        // Reset state
        #2;
        expectValid("rst_issue_valid", 1'b0);
        expectFull("rst_rs_full", 1'b0);
        checkOutput("rst_issue_op",   {60'd0, issue_op},   64'd0);
        checkOutput("rst_issue_a",    {32'd0, issue_a},    64'd0);
        checkOutput("rst_issue_dest", {60'd0, issue_dest}, 64'd0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;

        // 1: ready-at-dispatch ADD issues one cycle after the dispatch edge
        $display("[TB] test 1: ready dispatch");
        applyStimulus(1'b1, ALU_ADD, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0, 4'd3);
        pushExp(ALU_ADD, 32'd5, 32'd7, 4'd3);
        stepCycle();
        expectValid("t1_after_disp", 1'b0);
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
        stepCycle();
        expectValid("t1_issue", 1'b1);
        stepCycle();
        expectValid("t1_idle", 1'b0);

        // 2: SUB waits for tag 9, woken by cdb1
        $display("[TB] test 2: wakeup via cdb1");
        applyStimulus(1'b1, ALU_SUB, 32'd0, 1'b1, 4'd9, 32'd3, 1'b0, 4'd0, 4'd6);
        pushExp(ALU_SUB, 32'h100, 32'd3, 4'd6);
        stepCycle();
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            expectValid("t2_waiting", 1'b0);
        end
        setCdb(1, 1'b1, 4'd9, 32'h100);
        stepCycle();
        expectValid("t2_wake_edge", 1'b0);
        setCdb(1, 1'b0, 4'd0, 32'd0);
        stepCycle();
        expectValid("t2_issue", 1'b1);
        stepCycle();

        // 3: operand k captured from cdb0 in the dispatch cycle
        $display("[TB] test 3: dispatch snoop");
        applyStimulus(1'b1, ALU_OR, 32'd10, 1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 4'd11);
        setCdb(0, 1'b1, 4'd2, 32'd42);
        pushExp(ALU_OR, 32'd10, 32'd42, 4'd11);
        stepCycle();
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
        setCdb(0, 1'b0, 4'd0, 32'd0);
        stepCycle();
        expectValid("t3_issue", 1'b1);
        stepCycle();
        expectValid("t3_idle", 1'b0);

        // 4: fill all entries on tag 1, then drain in index order
        $display("[TB] test 4: fill and drain");
        for (int i = 0; i < 8; i++) begin
            expectFull("t4_not_full", 1'b0);
            applyStimulus(1'b1, ALU_XOR, 32'd0, 1'b1, 4'd1, 32'(i + 100), 1'b0, 4'd0, 4'(i));
            stepCycle();
        end
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
        expectFull("t4_full", 1'b1);
        for (int i = 0; i < 8; i++)
            pushExp(ALU_XOR, 32'hABC, 32'(i + 100), 4'(i));
        setCdb(0, 1'b1, 4'd1, 32'hABC);
        stepCycle();
        expectValid("t4_wake_edge", 1'b0);
        expectFull("t4_full_at_wake", 1'b1);
        setCdb(0, 1'b0, 4'd0, 32'd0);
        stepCycle();
        expectValid("t4_first_issue", 1'b1);
        expectFull("t4_full_drop", 1'b0);
        for (int i = 1; i < 8; i++) begin
            stepCycle();
            expectValid("t4_drain", 1'b1);
        end
        stepCycle();
        expectValid("t4_drained", 1'b0);

        // 5: clear discards pending entries and a same-cycle dispatch
        $display("[TB] test 5: clear");
        applyStimulus(1'b1, ALU_AND, 32'd0, 1'b1, 4'd5, 32'd1, 1'b0, 4'd0, 4'd12);
        stepCycle();
        applyStimulus(1'b1, ALU_SLT, 32'd2, 1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 4'd13);
        stepCycle();
        applyStimulus(1'b1, ALU_ADD, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 4'd14);
        clear = 1'b1;
        stepCycle();
        clear = 1'b0;
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
        expectValid("t5_after_clear", 1'b0);
        expectFull("t5_full", 1'b0);
        setCdb(0, 1'b1, 4'd5, 32'd77);
        setCdb(1, 1'b1, 4'd6, 32'd88);
        stepCycle();
        expectValid("t5_old_tags_a", 1'b0);
        setCdb(0, 1'b0, 4'd0, 32'd0);
        setCdb(1, 1'b0, 4'd0, 32'd0);
        stepCycle();
        expectValid("t5_old_tags_b", 1'b0);
        stepCycle();
        expectValid("t5_old_tags_c", 1'b0);

        // 6: rdy_in low freezes state and ignores a CDB broadcast
        $display("[TB] test 6: hold");
        applyStimulus(1'b1, ALU_SRA, 32'd0, 1'b1, 4'd7, 32'd4, 1'b0, 4'd0, 4'd8);
        stepCycle();
        applyStimulus(1'b1, ALU_SLL, 32'd1, 1'b0, 4'd0, 32'd2, 1'b0, 4'd0, 4'd4);
        stepCycle();
        applyStimulus(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
        rdy_in = 1'b0;
        setCdb(0, 1'b1, 4'd7, 32'd99);
        for (int i = 0; i < 4; i++) begin
            stepCycle();
            expectValid("t6_hold_valid", 1'b0);
            checkOutput("t6_hold_a",    {32'd0, issue_a},    {32'd0, last_exp.a});
            checkOutput("t6_hold_dest", {60'd0, issue_dest}, {60'd0, last_exp.dest});
            expectFull("t6_hold_full", 1'b0);
        end
        setCdb(0, 1'b0, 4'd0, 32'd0);
        rdy_in = 1'b1;
        pushExp(ALU_SLL, 32'd1, 32'd2, 4'd4);
        stepCycle();
        expectValid("t6_resume_issue", 1'b1);
        stepCycle();
        expectValid("t6_cdb_not_captured", 1'b0);
        setCdb(0, 1'b1, 4'd7, 32'd55);
        pushExp(ALU_SRA, 32'd55, 32'd4, 4'd8);
        stepCycle();
        setCdb(0, 1'b0, 4'd0, 32'd0);
        stepCycle();
        expectValid("t6_late_wake_issue", 1'b1);
        stepCycle();
        expectValid("t6_final_idle", 1'b0);

        checkOutput("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule
